// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scan driver with tear-free frame snapshots.
// Optional digit blinking is built when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_scanner #(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
`ifdef SEVEN_SEG_BLINK_EN
   ,parameter int BLINK_FRAMES = 64
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] digits_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blank_in,
`ifdef SEVEN_SEG_BLINK_EN
   input  logic [N_DIGITS-1:0]   blink_in,
`endif
   output logic [3:0]            bcd,
   output logic                  dp_n,
   output logic [N_DIGITS-1:0]   anode_n,
   output logic                  frame_start
);

   localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   typedef struct packed {
      logic [N_DIGITS-1:0][3:0] code;
      logic [N_DIGITS-1:0]      dp;
      logic [N_DIGITS-1:0]      blank;
`ifdef SEVEN_SEG_BLINK_EN
      logic [N_DIGITS-1:0]      blink;
`endif
   } snap_t;

   snap_t               snapIn, pending, active;
   logic                loadPend;
   logic [SW-1:0]       slotCnt;
   logic [DW-1:0]       digitIdx;
   logic                slotWrap, frameEnd, guardDone, digitLit;
   logic [N_DIGITS-1:0] anodeNxt;

   always_comb begin
      snapIn       = '0;
      snapIn.code  = digits_in;
      snapIn.dp    = dp_in;
      snapIn.blank = blank_in;
`ifdef SEVEN_SEG_BLINK_EN
      snapIn.blink = blink_in;
`endif
   end

   assign slotWrap = (slotCnt == SW'(REFRESH_DIV - 1));
   assign frameEnd = slotWrap && (digitIdx == DW'(N_DIGITS - 1));

   generate
      if (BLANK_CYCLES == 0) begin : gNoGuard
         assign guardDone = 1'b1;
      end else begin : gGuard
         assign guardDone = (slotCnt >= SW'(BLANK_CYCLES));
      end
   endgenerate

`ifdef SEVEN_SEG_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FW-1:0] frameCnt;
   logic          blinkHidden;

   assign digitLit = guardDone && !active.blank[digitIdx]
                     && !(blinkHidden && active.blink[digitIdx]);
`else
   assign digitLit = guardDone && !active.blank[digitIdx];
`endif

   // one-cold enable: only the scanned digit may be pulled low
   generate
      for (genvar g = 0; g < N_DIGITS; g++) begin : gAnode
         assign anodeNxt[g] = !((digitIdx == DW'(g)) && digitLit);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         slotCnt       <= '0;
         digitIdx      <= '0;
         pending       <= '0;
         pending.blank <= '1;
         active        <= '0;
         active.blank  <= '1;
         loadPend      <= 1'b0;
         bcd           <= 4'h0;
         dp_n          <= 1'b1;
         anode_n       <= '1;
         frame_start   <= 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
         frameCnt      <= '0;
         blinkHidden   <= 1'b0;
`endif
      end else begin
         slotCnt <= slotWrap ? '0 : slotCnt + 1'b1;
         if (slotWrap)
            digitIdx <= (digitIdx == DW'(N_DIGITS - 1)) ? '0 : digitIdx + 1'b1;

         // a load landing on the boundary goes straight to the display
         if (load) begin
            pending <= snapIn;
            if (frameEnd) begin
               active   <= snapIn;
               loadPend <= 1'b0;
            end else begin
               loadPend <= 1'b1;
            end
         end else if (frameEnd && loadPend) begin
            active   <= pending;
            loadPend <= 1'b0;
         end

         bcd         <= active.code[digitIdx];
         dp_n        <= ~active.dp[digitIdx];
         anode_n     <= anodeNxt;
         frame_start <= frameEnd;

`ifdef SEVEN_SEG_BLINK_EN
         if (frameEnd) begin
            if (frameCnt == FW'(BLINK_FRAMES - 1)) begin
               frameCnt    <= '0;
               blinkHidden <= ~blinkHidden;
            end else begin
               frameCnt    <= frameCnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexed scan driver for the board's common-anode 7-segment display bank. Holds a tear-free snapshot of N_DIGITS nibble codes with per-digit decimal-point and blank flags. Steps through the digits one per refresh slot and drives the active digit's code and dp into the seven-segment decoder stage. Drives the matching anode enable, with a guard interval at the start of each slot so no digit shows the previous digit's segments.

Parameters:
N_DIGITS, 4, number of multiplexed digits (>=2).
REFRESH_DIV, 100000, clk cycles per digit slot (>=2).
BLANK_CYCLES, 1000, guard cycles at slot start with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
load  input  1  one-cycle strobe; capture digits_in/dp_in/blank_in.
digits_in  input  4*N_DIGITS  nibble codes; digit i = bits [4i+3:4i]; codes 0-F as the decoder defines (A='-', B=F, C=C, D=n, E=d, F=U).
dp_in  input  N_DIGITS  decimal point request per digit, 1 = lit.
blank_in  input  N_DIGITS  1 = digit dark.
bcd  output  4  code of the current digit, to the decoder's BCD input.
dp_n  output  1  decimal point, active-low, to the decoder's dp input (passed straight to the pin).
anode_n  output  N_DIGITS  digit enables, active-low, one-cold.
frame_start  output  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- All outputs registered. Reset values: anode_n all 1, bcd = 4'h0, dp_n = 1, frame_start = 0.
- Reset clears slot_cnt = 0, digit_idx = 0, pending and active snapshots = 0, blank flags = all 1, load_pend = 0.
- slot_cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, digit_idx increments mod N_DIGITS: N_DIGITS-1 wraps to 0.
- Frame boundary: the cycle where slot_cnt wraps and digit_idx goes N_DIGITS-1 -> 0. frame_start is asserted on the next cycle, coincident with slot_cnt = 0, digit_idx = 0.
- Load path:
  - load = 1 copies the inputs into the pending snapshot and sets load_pend.
  - At a frame boundary with load_pend = 1: pending is copied to active and load_pend clears.
  - load on the frame-boundary cycle itself: the input data goes directly to active, and pending takes the same data. No frame shows stale data after that load.
  - Consecutive loads: the last one before the boundary wins.
  - The display never changes contents mid-frame.
- Output timing: one register stage. In the cycle after slot_cnt = s and digit_idx = i:
  - bcd = active code[i], dp_n = ~active dp[i].
  - anode_n[i] = 0 iff s >= BLANK_CYCLES and active blank[i] = 0.
  - All other anode bits are 1.
  - When BLANK_CYCLES = 0, no guard interval exists.
- Blanked digit: anode stays 1, but bcd/dp_n still follow the snapshot.
- rst in the middle of a scan: takes effect on the next edge, overriding load. All anodes go off the next cycle, and scanning restarts at digit 0.
- Counter widths: $clog2 of REFRESH_DIV and of N_DIGITS, minimum 1 bit. No other arithmetic.

Optional Feature:
SEVEN_SEG_BLINK_EN.
- Defined:
  - Adds input port blink_in [N_DIGITS], captured with load like the other snapshot fields.
  - Adds parameter BLINK_FRAMES (default 64).
  - A frame counter toggles blink_phase every BLINK_FRAMES frame boundaries. Reset phase = visible.
  - While the phase is hidden, digits with blink = 1 are forced dark (anode = 1).
  - Blink state updates only at frame boundaries.
- Undefined: no blink_in port, no frame counter, and behaviour exactly as above.

Test Plan:
Parameters for all scenarios: N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset release -> anode_n=4'b1111 indefinitely (all blank); first frame_start 32 cycles after release; slot index advances every 8 cycles.
2. load with digits_in=16'h4321, dp_in=4'b0100, blank_in=0 during frame -> no change until next frame_start. Then per slot: 2 cycles anode_n=1111, then 6 cycles one-cold with bcd 1,2,3,4 for digits 0..3; dp_n=0 only during digit 2.
3. load on the frame-boundary cycle with digits_in=16'hBEEF -> the frame starting the next cycle shows F,E,E,B. Two loads (16'h1111 then 16'h2222) inside one frame -> the next frame shows 2222.
4. blank_in=4'b1010 -> anode_n[1] and anode_n[3] never 0; digits 0 and 2 are lit 6 of 8 cycles per slot.
5. rst asserted mid digit 2 -> the next cycle shows anode_n=1111, bcd=0, dp_n=1; after release, scan restarts at digit 0 with blank snapshot.
6. SEVEN_SEG_BLINK_EN with BLINK_FRAMES=2, blink_in=4'b0001 -> digit 0 lit for frames 0-1, dark for frames 2-3, lit for 4-5; other digits unaffected.
